logic_result_stage: RTL and testbench
=====================================

LOGIC_RESULT_STAGE -- requirements
Module: logic_result_stage

Interface
REQ-001 Parameter: WIDTH, 16, result datapath width in bits.
REQ-002 Parameter: SELW, 4, operation-select width carried alongside each result.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: in_valid  input  1  upstream logic unit presents a result this cycle.
REQ-006 Port: in_ready  output  1  stage can accept a result this cycle.
REQ-007 Port: in_result  input  WIDTH  combinational result from the logic unit.
REQ-008 Port: in_sel  input  SELW  select code that produced in_result.
REQ-009 Port: in_wr_acc  input  1  on acceptance, also load in_result into the accumulator.
REQ-010 Port: out_valid  output  1  head entry available downstream.
REQ-011 Port: out_ready  input  1  downstream consumes head entry this cycle.
REQ-012 Port: out_result  output  WIDTH  head entry result.
REQ-013 Port: out_sel  output  SELW  head entry select code.
REQ-014 Port: out_zero  output  1  head result is all zeros.
REQ-015 Port: out_neg  output  1  head result MSB.
REQ-016 Port: out_parity  output  1  XOR-reduction of head result (1 = odd ones count).
REQ-017 Port: acc_out  output  WIDTH  accumulator value, fed back as operand A of the logic unit.
REQ-018 Port: op_count  output  8  number of entries popped since reset, modulo 256.

Function
REQ-019 Stage SHALL be a 2-entry FIFO of {result, sel, zero, neg, parity}; occupancy states EMPTY(0), ONE(1), FULL(2).
REQ-020 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-021 in_ready SHALL be 1 iff occupancy < 2 and rst is low; it SHALL NOT depend on out_ready.
REQ-022 out_valid SHALL be 1 iff occupancy > 0; out_* SHALL be driven from registered head entry only.
REQ-023 Latency: an entry pushed in cycle N SHALL be visible on out_* in cycle N+1 when FIFO was empty.
REQ-024 Flags SHALL be computed from in_result at push and stored with the entry; they SHALL NOT be recomputed at output.
REQ-025 Transitions: EMPTY+push->ONE; ONE+push-only->FULL; ONE+pop-only->EMPTY; ONE+push+pop->ONE with new entry at head next cycle; FULL+pop->ONE; FULL+push attempt impossible (in_ready=0).
REQ-026 Entries SHALL leave in push order; no entry SHALL be dropped or duplicated.
REQ-027 While out_valid && !out_ready, out_* SHALL remain stable.
REQ-028 Accumulator SHALL load in_result at the clock edge of a push with in_wr_acc=1; acc_out reflects it from cycle N+1; in_wr_acc without push SHALL be ignored.
REQ-029 op_count SHALL increment by 1 per pop and wrap 255->0.
REQ-030 When out_valid=0, out_result, out_sel and flags SHALL read 0.

Reset
REQ-031 While rst=1 at a clock edge: occupancy->0, acc_out->0, op_count->0, all stored entries cleared.
REQ-032 During rst=1, in_ready=0 and out_valid=0; any in_valid or out_ready SHALL be ignored.
REQ-033 Reset asserted with FIFO FULL SHALL discard both entries; first cycle after deassertion in_ready=1, out_valid=0.

Verification
REQ-034 Single push: in_result=16'h0000, in_sel=4'h3, out_ready=1 -> next cycle out_valid=1, out_zero=1, out_neg=0, out_parity=0; following cycle op_count=1.
REQ-035 Backpressure: out_ready=0, push 16'h8001 then 16'h00FF -> in_ready=0 after second push; head 16'h8001 with out_neg=1, out_parity=0 held stable; release -> 16'h00FF next (parity=0, neg=0).
REQ-036 Simultaneous push/pop at ONE: head 16'h1234 popped while 16'hABCD pushed -> occupancy stays 1, next head 16'hABCD, op_count+1.
REQ-037 Accumulator: push 16'h5A5A with in_wr_acc=1 -> acc_out=16'h5A5A next cycle; in_wr_acc=1 with in_valid=0 -> acc_out unchanged.
REQ-038 Wrap: 256 consecutive pops -> op_count returns to 0.
REQ-039 Reset mid-operation: FIFO FULL, acc_out=16'hFFFF, rst=1 for one cycle -> occupancy 0, acc_out=0, op_count=0, in_ready=1 after release.

Source files
------------

// File: rtl/logic_result_stage.sv
// Result stage behind the logic unit: a 2-entry skid FIFO with stored result flags,
// plus the operand-A accumulator and a count of retired results.
module logic_result_stage #(
  parameter int WIDTH = 16,
  parameter int SELW  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [SELW-1:0]  in_sel,
  input  logic             in_wr_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [SELW-1:0]  out_sel,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_parity,
  output logic [WIDTH-1:0] acc_out,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [SELW-1:0]  sel;
    logic             zero;
    logic             neg;
    logic             parity;
  } entry_t;

  occ_t   state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;
  entry_t in_entry;
  logic   push, pop;

  // Flags are captured with the entry so the output side is a pure register read.
  always_comb begin
    in_entry.result = in_result;
    in_entry.sel    = in_sel;
    in_entry.zero   = (in_result == '0);
    in_entry.neg    = in_result[WIDTH-1];
    in_entry.parity = ^in_result;
  end

  assign in_ready  = (state_q != FULL) && !rst;
  assign out_valid = (state_q != EMPTY) && !rst;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          tail_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          head_d  = '0;
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_d  = tail_q;
          tail_d  = '0;
          state_d = ONE;
        end
      end
      default: begin
        head_d  = '0;
        tail_d  = '0;
        state_d = EMPTY;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the two entry slots are plain registers, and a reset must discard
      // whatever they held, so they are cleared here rather than left unreset.
      state_q  <= EMPTY;
      head_q   <= '0;
      tail_q   <= '0;
      acc_out  <= '0;
      op_count <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      if (push && in_wr_acc) acc_out <= in_result;
      if (pop) op_count <= op_count + 8'd1;
    end
  end

  assign out_result = out_valid ? head_q.result : '0;
  assign out_sel    = out_valid ? head_q.sel    : '0;
  assign out_zero   = out_valid && head_q.zero;
  assign out_neg    = out_valid && head_q.neg;
  assign out_parity = out_valid && head_q.parity;

endmodule

// File: tb/tb_logic_result_stage.sv
// Directed bench for logic_result_stage: reset, flags, backpressure, push/pop at ONE,
// accumulator, op_count wrap and reset while full.
module tb_logic_result_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [3:0]  in_sel;
  logic        in_wr_acc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [3:0]  out_sel;
  logic        out_zero;
  logic        out_neg;
  logic        out_parity;
  logic [15:0] acc_out;
  logic [7:0]  op_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_cnt;

  logic_result_stage #(.WIDTH(16), .SELW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_sel     (in_sel),
    .in_wr_acc  (in_wr_acc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_sel    (out_sel),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_parity (out_parity),
    .acc_out    (acc_out),
    .op_count   (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_head(input string tag, input logic [15:0] res, input logic [3:0] sel,
                            input logic z, input logic n, input logic p);
    check({tag, ".valid"},  32'(out_valid),  32'd1);
    check({tag, ".result"}, 32'(out_result), 32'(res));
    check({tag, ".sel"},    32'(out_sel),    32'(sel));
    check({tag, ".zero"},   32'(out_zero),   32'(z));
    check({tag, ".neg"},    32'(out_neg),    32'(n));
    check({tag, ".parity"}, 32'(out_parity), 32'(p));
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".valid"},  32'(out_valid),  32'd0);
    check({tag, ".result"}, 32'(out_result), 32'd0);
    check({tag, ".flags"},  32'({out_zero, out_neg, out_parity}), 32'd0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] r, input logic [3:0] s,
                       input logic wa, input logic rdy);
    in_valid  = v;
    in_result = r;
    in_sel    = s;
    in_wr_acc = wa;
    out_ready = rdy;
  endtask

  initial begin
    // Reset with traffic on the inputs: it must be ignored.
    rst = 1'b1;
    drive(1'b1, 16'h7777, 4'h7, 1'b1, 1'b1);
    tick();
    tick();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'd1);
    check_empty("post_rst");
    check("post_rst.acc", 32'(acc_out), 32'd0);
    check("post_rst.count", 32'(op_count), 32'd0);
    exp_cnt = 8'd0;

    // Single zero push, consumed immediately.
    drive(1'b1, 16'h0000, 4'h3, 1'b0, 1'b1);
    tick();
    check_head("single", 16'h0000, 4'h3, 1'b1, 1'b0, 1'b0);
    check("single.count0", 32'(op_count), 32'd0);
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    check("single.count1", 32'(op_count), 32'(exp_cnt));
    check_empty("single.drained");

    // Backpressure: fill to FULL and hold.
    drive(1'b1, 16'h8001, 4'h1, 1'b0, 1'b0);
    tick();
    check("bp.ready_one", 32'(in_ready), 32'd1);
    drive(1'b1, 16'h00FF, 4'h2, 1'b0, 1'b0);
    tick();
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    check("bp.ready_full", 32'(in_ready), 32'd0);
    check_head("bp.hold0", 16'h8001, 4'h1, 1'b0, 1'b1, 1'b0);
    tick();
    check_head("bp.hold1", 16'h8001, 4'h1, 1'b0, 1'b1, 1'b0);
    check("bp.count_held", 32'(op_count), 32'(exp_cnt));
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    check_head("bp.second", 16'h00FF, 4'h2, 1'b0, 1'b0, 1'b0);
    check("bp.ready_again", 32'(in_ready), 32'd1);
    check("bp.count", 32'(op_count), 32'(exp_cnt));
    tick();
    exp_cnt++;
    check_empty("bp.drained");

    // Simultaneous push and pop at ONE.
    drive(1'b1, 16'h1234, 4'h5, 1'b0, 1'b0);
    tick();
    check_head("pp.first", 16'h1234, 4'h5, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 16'hABCD, 4'h6, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    check_head("pp.swap", 16'hABCD, 4'h6, 1'b0, 1'b1, 1'b0);
    check("pp.ready", 32'(in_ready), 32'd1);
    check("pp.count", 32'(op_count), 32'(exp_cnt));
    drive(1'b1, 16'h0001, 4'h9, 1'b0, 1'b0);
    tick();
    check("pp.full", 32'(in_ready), 32'd0);
    check_head("pp.still", 16'hABCD, 4'h6, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    check_head("pp.next", 16'h0001, 4'h9, 1'b0, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    check_empty("pp.drained");
    check("pp.count2", 32'(op_count), 32'(exp_cnt));

    // Accumulator load on push only.
    drive(1'b1, 16'h5A5A, 4'hA, 1'b1, 1'b1);
    tick();
    check("acc.load", 32'(acc_out), 32'h5A5A);
    drive(1'b0, 16'h1111, 4'h0, 1'b1, 1'b1);
    tick();
    exp_cnt++;
    check("acc.ignored", 32'(acc_out), 32'h5A5A);
    check_empty("acc.drained");

    // Streaming 256 entries: ordering every cycle, then op_count wraps back.
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 16'(i * 3 + 1), 4'(i), 1'b0, 1'b1);
      tick();
      if (i > 0) exp_cnt++;
      check("wrap.order", 32'(out_result), 32'(i * 3 + 1));
    end
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    tick();
    exp_cnt++;
    check("wrap.count", 32'(op_count), 32'(exp_cnt));
    check("wrap.count_literal", 32'(op_count), 32'd7);
    check_empty("wrap.drained");

    // Reset while FULL with a loaded accumulator.
    drive(1'b1, 16'hFFFF, 4'hF, 1'b1, 1'b0);
    tick();
    drive(1'b1, 16'h0F0F, 4'hE, 1'b0, 1'b0);
    tick();
    check("mid.full", 32'(in_ready), 32'd0);
    check("mid.acc", 32'(acc_out), 32'hFFFF);
    rst = 1'b1;
    drive(1'b1, 16'h2222, 4'h2, 1'b1, 1'b1);
    #1;
    check("mid.rst_in_ready", 32'(in_ready), 32'd0);
    check("mid.rst_out_valid", 32'(out_valid), 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b0);
    #1;
    check("mid.in_ready", 32'(in_ready), 32'd1);
    check_empty("mid");
    check("mid.acc0", 32'(acc_out), 32'd0);
    check("mid.count0", 32'(op_count), 32'd0);
    drive(1'b1, 16'h0042, 4'h4, 1'b0, 1'b0);
    tick();
    check_head("mid.fresh", 16'h0042, 4'h4, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 16'h0000, 4'h0, 1'b0, 1'b1);
    tick();
    check_empty("mid.no_stale");
    check("mid.count1", 32'(op_count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
